edge_thresh_stats: RTL
======================

EDGE_THRESH_STATS -- requirements
Module: edge_thresh_stats

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL expose parameter PIXELS_PER_BEAT, default 16, giving pixels per beat.
REQ-002 The block SHALL expose parameter IMAGE_DIM, default 512, giving image width and height in pixels (square frame).
REQ-003 The block SHALL expose parameter DATA_WIDTH, default 8*PIXELS_PER_BEAT, giving the beat width in bits.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-006 The block SHALL have port stall, input, 1, the global stall; when high, every register holds its value.
REQ-007 The block SHALL have port in_valid, input, 1, marking the Sobel magnitude beat as valid.
REQ-008 The block SHALL have port inp_frame, input, DATA_WIDTH, carrying 8-bit magnitudes with the leftmost pixel in the MSB byte.
REQ-009 The block SHALL have port threshold, input, 8, the edge threshold.
REQ-010 The block SHALL have port out_frame, output, DATA_WIDTH, carrying the binary mask: 0xFF for an edge pixel, 0x00 otherwise, in the same byte order.
REQ-011 The block SHALL have port out_valid, output, 1, qualifying out_frame.
REQ-012 The block SHALL have port out_sof, output, 1, marking the first beat of a frame.
REQ-013 The block SHALL have port out_eol, output, 1, marking the last beat of a row.
REQ-014 The block SHALL have port edge_count, output, 2*$clog2(IMAGE_DIM)+1, holding the edge-pixel total of the last complete frame.
REQ-015 The block SHALL have port count_valid, output, 1, a one-cycle pulse signalling that edge_count was updated.

Function
REQ-016 A beat SHALL be accepted only on a rising edge where in_valid=1 and stall=0.
REQ-017 The block SHALL track position with col_counter (beats, 0..IMAGE_DIM/PIXELS_PER_BEAT-1) and row_counter (0..IMAGE_DIM-1); both advance only on acceptance, col wraps to 0 and increments row, and row wraps to 0 after IMAGE_DIM-1.
REQ-018 The block SHALL latch threshold into an internal register on acceptance of the beat at (row 0, col 0); all pixels of that frame SHALL use the latched value, including the first beat.
REQ-019 A pixel SHALL be an edge when its magnitude is strictly greater than the latched threshold, using an unsigned compare.
REQ-020 Border pixels SHALL be forced to 0x00 and not counted: row 0, row IMAGE_DIM-1, pixel column 0 (MSB byte of col 0) and pixel column IMAGE_DIM-1 (LSB byte of the last col).
REQ-021 Stage 1 output registers (out_frame, out_valid, out_sof, out_eol) SHALL update on every non-stalled edge, so latency is 1 cycle; out_valid equals the accepted condition, and out_sof/out_eol are valid only when out_valid=1.
REQ-022 Stage 1 SHALL also register the per-beat popcount of edge pixels, $clog2(PIXELS_PER_BEAT)+1 bits wide.
REQ-023 Stage 2 SHALL add the registered popcount to a frame accumulator on each non-stalled edge where stage-1 valid=1.
REQ-024 For the frame's last beat, stage 2 SHALL load edge_count with accumulator+popcount and clear the accumulator, and count_valid SHALL be 1 for exactly one non-stalled cycle, 2 edges after acceptance of that beat.
REQ-025 If stall is asserted while count_valid=1, count_valid SHALL hold until the next non-stalled edge, then drop.
REQ-026 The accumulator SHALL never saturate; its width SHALL fit IMAGE_DIM*IMAGE_DIM.
REQ-027 Gaps where in_valid=0 SHALL neither advance counters nor change the accumulator.

Reset
REQ-028 On reset=1 at a rising edge, the block SHALL clear col_counter, row_counter, the accumulator, the latched threshold, out_frame, out_valid, out_sof, out_eol, edge_count and count_valid to 0; reset SHALL override stall.
REQ-029 A reset mid-frame SHALL discard the partial frame; the next accepted beat is (row 0, col 0).

Verification (IMAGE_DIM=64, PIXELS_PER_BEAT=16: 4 beats/row, 256 beats/frame)
REQ-030 The bench SHALL drive all pixels 0xFF with threshold 0x80 for one frame; required response: interior mask 0xFF, border bytes 0x00, edge_count=62*62=3844, one count_valid pulse 2 cycles after the last beat.
REQ-031 The bench SHALL drive all pixels equal to threshold (0x40); required response: mask all 0x00, edge_count=0.
REQ-032 The bench SHALL change threshold from 0x10 to 0xF0 mid-frame on all-0x80 data; required response: that frame still counts 3844, and the next frame counts 0.
REQ-033 The bench SHALL insert random in_valid gaps and stall bursts, including stall during the count_valid cycle; required response: identical mask and count to the gap-free run, and count_valid seen exactly once.
REQ-034 The bench SHALL assert reset at beat 100, then send a full frame; required response: out_sof on the first post-reset beat, and edge_count reflects only the new frame.
REQ-035 The bench SHALL check flags; required response: out_sof only on (0,0), and out_eol on col 3 of every row.

Source files
------------

// File: rtl/edge_thresh_stats.sv
// Thresholds Sobel magnitude beats into a binary edge mask (border forced to 0)
// and reports the per-frame edge-pixel count through a two-stage pipeline.
module edge_thresh_stats #(
  parameter int unsigned PIXELS_PER_BEAT = 16,
  parameter int unsigned IMAGE_DIM       = 512,
  parameter int unsigned DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          in_valid,
  input  logic [DATA_WIDTH-1:0]         inp_frame,
  input  logic [7:0]                    threshold,
  output logic [DATA_WIDTH-1:0]         out_frame,
  output logic                          out_valid,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic [2*$clog2(IMAGE_DIM):0]  edge_count,
  output logic                          count_valid
);

  localparam int unsigned COLS  = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned ROW_W = $clog2(IMAGE_DIM);
  localparam int unsigned POP_W = $clog2(PIXELS_PER_BEAT) + 1;
  localparam int unsigned CNT_W = 2 * $clog2(IMAGE_DIM) + 1;

  logic [COL_W-1:0]      r_col;
  logic [ROW_W-1:0]      r_row;
  logic [7:0]            r_thr;
  logic [DATA_WIDTH-1:0] r_out_frame;
  logic                  r_out_valid;
  logic                  r_out_sof;
  logic                  r_out_eol;
  logic [POP_W-1:0]      r_pop;
  logic                  r_last;
  logic [CNT_W-1:0]      r_accum;
  logic [CNT_W-1:0]      r_edge_count;
  logic                  r_count_valid;

  logic                  w_acc;
  logic                  w_first;
  logic                  w_col_last;
  logic                  w_row_last;
  logic                  w_row_border;
  logic [7:0]            w_thr;
  logic [7:0]            w_pix;
  logic                  w_border;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [POP_W-1:0]      w_pop;

  assign w_acc        = in_valid && !stall;
  assign w_first      = (r_row == '0) && (r_col == '0);
  assign w_col_last   = (r_col == COL_W'(COLS - 1));
  assign w_row_last   = (r_row == ROW_W'(IMAGE_DIM - 1));
  assign w_row_border = (r_row == '0) || w_row_last;
  // The first beat of a frame must already see the new threshold, before it is latched.
  assign w_thr        = w_first ? threshold : r_thr;

  // Per-pixel compare; pixel 0 is the leftmost pixel in the MSB byte.
  always_comb begin
    w_mask   = '0;
    w_pop    = '0;
    w_pix    = '0;
    w_border = 1'b0;
    for (int p = 0; p < int'(PIXELS_PER_BEAT); p++) begin
      w_pix    = inp_frame[(int'(PIXELS_PER_BEAT) - 1 - p) * 8 +: 8];
      w_border = w_row_border
              || ((r_col == '0) && (p == 0))
              || (w_col_last && (p == int'(PIXELS_PER_BEAT) - 1));
      if (!w_border && (w_pix > w_thr)) begin
        w_mask[(int'(PIXELS_PER_BEAT) - 1 - p) * 8 +: 8] = 8'hFF;
        w_pop = w_pop + POP_W'(1);
      end
    end
  end

  // Frame position and per-frame threshold latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      r_thr <= '0;
    end else if (w_acc) begin
      if (w_first) r_thr <= threshold;
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Stage 1: mask, flags and beat popcount.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_frame <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_pop       <= '0;
      r_last      <= 1'b0;
    end else if (!stall) begin
      r_out_frame <= w_mask;
      r_out_valid <= in_valid;
      r_out_sof   <= in_valid && w_first;
      r_out_eol   <= in_valid && w_col_last;
      r_pop       <= w_pop;
      r_last      <= in_valid && w_col_last && w_row_last;
    end
  end

  // Stage 2: frame accumulation and count publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_accum       <= '0;
      r_edge_count  <= '0;
      r_count_valid <= 1'b0;
    end else if (!stall) begin
      r_count_valid <= 1'b0;
      if (r_out_valid) begin
        if (r_last) begin
          r_edge_count  <= r_accum + CNT_W'(r_pop);
          r_accum       <= '0;
          r_count_valid <= 1'b1;
        end else begin
          r_accum <= r_accum + CNT_W'(r_pop);
        end
      end
    end
  end

  assign out_frame   = r_out_frame;
  assign out_valid   = r_out_valid;
  assign out_sof     = r_out_sof;
  assign out_eol     = r_out_eol;
  assign edge_count  = r_edge_count;
  assign count_valid = r_count_valid;

endmodule
